// File: rtl/keypad_entry_if.sv
// Key-event input, scan tick and command handshake between keypad_entry_ctrl (master) and its neighbours (slave).
interface keypad_entry_if #(
  parameter int DIGITS = 4
);
  logic                  o_pls_1k;
  logic                  i_key_valid;
  logic [4:0]            i_key_value;
  logic                  o_cmd_valid;
  logic                  i_cmd_ready;
  logic [2:0]            o_cmd_op;
  logic [4*DIGITS-1:0]   o_cmd_data;
  logic [3:0]            o_digit_cnt;
  logic                  o_entry_busy;
  logic                  o_err;

  modport master (
    output o_pls_1k, o_cmd_valid, o_cmd_op, o_cmd_data, o_digit_cnt, o_entry_busy, o_err,
    input  i_key_valid, i_key_value, i_cmd_ready
  );

  modport slave (
    input  o_pls_1k, o_cmd_valid, o_cmd_op, o_cmd_data, o_digit_cnt, o_entry_busy, o_err,
    output i_key_valid, i_key_value, i_cmd_ready
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Scan-tick prescaler plus BCD key-entry FSM issuing NUM/function commands; all outputs registered, 1-cycle key-to-output latency.
// Command held on valid until ready; keys arriving while a command is pending are dropped with an error pulse.
module keypad_entry_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DIGITS     = 4,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  keypad_entry_if.master kif
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(TIMEOUT_MS + 1);
  localparam int W   = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [PW-1:0] prescale_q;
  logic          pls_q;
  logic [1:0]    state_q;
  logic [W-1:0]  buf_q;
  logic [3:0]    cnt_q;
  logic [2:0]    op_q;
  logic          vld_q;
  logic          err_q;
  logic [TW-1:0] tcnt_q;

  logic       is_digit, is_clr, is_bksp, is_enter, is_func;
  logic [3:0] digit;
  logic [2:0] func_op;

  // Pulse is registered one count early so it lines up with prescale == DIV-1.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prescale_q <= '0;
      pls_q      <= 1'b0;
    end else begin
      prescale_q <= (prescale_q == PW'(DIV - 1)) ? '0 : prescale_q + PW'(1);
      pls_q      <= (prescale_q == PW'(DIV - 2));
    end
  end

  always_comb begin
    is_digit = 1'b0;
    is_clr   = 1'b0;
    is_bksp  = 1'b0;
    is_enter = 1'b0;
    is_func  = 1'b0;
    digit    = 4'd0;
    func_op  = 3'd0;
    if (kif.i_key_value >= 5'd1 && kif.i_key_value <= 5'd9) begin
      is_digit = 1'b1;
      digit    = kif.i_key_value[3:0];
    end else if (kif.i_key_value == 5'd10) begin
      is_digit = 1'b1;
    end else if (kif.i_key_value == 5'd11) begin
      is_clr = 1'b1;
    end else if (kif.i_key_value == 5'd12) begin
      is_bksp = 1'b1;
    end else if (kif.i_key_value == 5'd13) begin
      is_enter = 1'b1;
    end else if (kif.i_key_value >= 5'd14 && kif.i_key_value <= 5'd20) begin
      is_func = 1'b1;
      func_op = 3'(kif.i_key_value - 5'd13);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (kif.i_key_valid) begin
            if (is_digit) begin
              buf_q   <= W'(digit);
              cnt_q   <= 4'd1;
              tcnt_q  <= '0;
              state_q <= S_ENTRY;
            end else if (is_func) begin
              op_q    <= func_op;
              vld_q   <= 1'b1;
              buf_q   <= '0;
              state_q <= S_ISSUE;
            end else if (!is_clr && !is_bksp) begin
              err_q <= 1'b1;
            end
          end
        end
        S_ENTRY: begin
          if (kif.i_key_valid) begin
            tcnt_q <= '0;
            if (is_digit) begin
              if (cnt_q < 4'(DIGITS)) begin
                buf_q <= (buf_q << 4) | W'(digit);
                cnt_q <= cnt_q + 4'd1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (is_bksp) begin
              buf_q <= buf_q >> 4;
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_q <= S_IDLE;
            end else if (is_clr) begin
              buf_q   <= '0;
              cnt_q   <= 4'd0;
              state_q <= S_IDLE;
            end else if (is_enter || is_func) begin
              op_q    <= is_enter ? 3'd0 : func_op;
              vld_q   <= 1'b1;
              state_q <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end else if (pls_q) begin
            // The >= compare makes the counter saturate even if TIMEOUT_MS is tiny.
            if (tcnt_q >= TW'(TIMEOUT_MS - 1)) begin
              buf_q   <= '0;
              cnt_q   <= 4'd0;
              tcnt_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (kif.i_key_valid) err_q <= 1'b1;
          if (vld_q && kif.i_cmd_ready) begin
            vld_q   <= 1'b0;
            op_q    <= 3'd0;
            buf_q   <= '0;
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kif.o_pls_1k     = pls_q;
  assign kif.o_cmd_valid  = vld_q;
  assign kif.o_cmd_op     = op_q;
  assign kif.o_cmd_data   = buf_q;
  assign kif.o_digit_cnt  = cnt_q;
  assign kif.o_entry_busy = (state_q != S_IDLE);
  assign kif.o_err        = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: hand-derived vector table, directed corner sequences and random keys against a queue-based model.
module tb_keypad_entry_ctrl;
  localparam int CLK_HZ     = 4;
  localparam int SCAN_HZ    = 1;
  localparam int DIGITS     = 4;
  localparam int TIMEOUT_MS = 5;
  localparam int DIV        = CLK_HZ / SCAN_HZ;
  localparam int W          = 4 * DIGITS;

  logic i_clk;
  logic i_rstn;

  keypad_entry_if #(.DIGITS(DIGITS)) kif ();

  keypad_entry_ctrl #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(DIGITS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .kif(kif)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nmis = 0;

  typedef enum int {M_IDLE, M_ENTRY, M_ISSUE} mode_t;
  mode_t      m_mode;
  int         m_q[$];
  logic       m_vld;
  logic [2:0] m_op;
  logic       m_err;
  int         m_ticks;
  int         m_edges;

  typedef struct {
    logic         kv;
    logic [4:0]   code;
    logic         rdy;
    logic         vld;
    logic [2:0]   op;
    logic [W-1:0] data;
    logic [3:0]   cnt;
    logic         busy;
    logic         err;
  } vec_t;
  vec_t tbl[23];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_data();
    logic [W-1:0] d;
    d = '0;
    foreach (m_q[i]) d = (d << 4) | W'(m_q[i]);
    return d;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q.delete();
    m_vld = 1'b0;
    m_op = 3'd0;
    m_err = 1'b0;
    m_ticks = 0;
    m_edges = 0;
  endtask

  task automatic model_edge(input logic v, input int code, input logic rdy);
    bit pls, is_dig, is_fn;
    int dval;
    pls    = (m_edges % DIV) == DIV - 1;
    is_dig = (code >= 1 && code <= 10);
    is_fn  = (code >= 14 && code <= 20);
    dval   = (code == 10) ? 0 : code;
    m_err  = 1'b0;
    case (m_mode)
      M_IDLE: if (v) begin
        if (is_dig) begin
          m_q.delete(); m_q.push_back(dval); m_ticks = 0; m_mode = M_ENTRY;
        end else if (is_fn) begin
          m_op = 3'(code - 13); m_vld = 1'b1; m_mode = M_ISSUE;
        end else if (code != 11 && code != 12) begin
          m_err = 1'b1;
        end
      end
      M_ENTRY: if (v) begin
        m_ticks = 0;
        if (is_dig) begin
          if (m_q.size() < DIGITS) m_q.push_back(dval);
          else m_err = 1'b1;
        end else if (code == 12) begin
          void'(m_q.pop_back());
          if (m_q.size() == 0) m_mode = M_IDLE;
        end else if (code == 11) begin
          m_q.delete(); m_mode = M_IDLE;
        end else if (code == 13 || is_fn) begin
          m_op = (code == 13) ? 3'd0 : 3'(code - 13); m_vld = 1'b1; m_mode = M_ISSUE;
        end else begin
          m_err = 1'b1;
        end
      end else if (pls) begin
        m_ticks++;
        if (m_ticks >= TIMEOUT_MS) begin
          m_q.delete(); m_mode = M_IDLE;
        end
      end
      M_ISSUE: begin
        if (v) m_err = 1'b1;
        if (rdy) begin
          m_vld = 1'b0; m_op = 3'd0; m_q.delete(); m_mode = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_edges++;
  endtask

  task automatic check_model();
    cmp("model.pls",  32'(kif.o_pls_1k),     32'((m_edges % DIV) == DIV - 1));
    cmp("model.vld",  32'(kif.o_cmd_valid),  32'(m_vld));
    cmp("model.op",   32'(kif.o_cmd_op),     32'(m_op));
    cmp("model.data", 32'(kif.o_cmd_data),   32'(m_data()));
    cmp("model.cnt",  32'(kif.o_digit_cnt),  32'(m_q.size()));
    cmp("model.busy", 32'(kif.o_entry_busy), 32'(m_mode != M_IDLE));
    cmp("model.err",  32'(kif.o_err),        32'(m_err));
  endtask

  // Called at a negedge: drive, let one posedge pass, sample on the next negedge.
  task automatic step(input logic v, input logic [4:0] c, input logic r);
    kif.i_key_valid = v;
    kif.i_key_value = c;
    kif.i_cmd_ready = r;
    @(posedge i_clk);
    model_edge(v, int'(c), r);
    @(negedge i_clk);
    check_model();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] mask;
    int n;
    logic saw_err, saw_vld;

    tbl[0]  = '{1'b1, 5'd1,  1'b1, 1'b0, 3'd0, 16'h0001, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'd2,  1'b1, 1'b0, 3'd0, 16'h0012, 4'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd3,  1'b1, 1'b0, 3'd0, 16'h0123, 4'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd13, 1'b1, 1'b1, 3'd0, 16'h0123, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 5'd0,  1'b1, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd1,  1'b0, 1'b0, 3'd0, 16'h0001, 4'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd2,  1'b0, 1'b0, 3'd0, 16'h0012, 4'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd3,  1'b0, 1'b0, 3'd0, 16'h0123, 4'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd4,  1'b0, 1'b0, 3'd0, 16'h1234, 4'd4, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd5,  1'b0, 1'b0, 3'd0, 16'h1234, 4'd4, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 5'd0,  1'b0, 1'b0, 3'd0, 16'h1234, 4'd4, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd11, 1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 5'd31, 1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 5'd13, 1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 5'd0,  1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 5'd14, 1'b0, 1'b1, 3'd1, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 5'd5,  1'b0, 1'b1, 3'd1, 16'h0000, 4'd0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 5'd0,  1'b0, 1'b1, 3'd1, 16'h0000, 4'd0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 5'd2,  1'b1, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 5'd0,  1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 5'd12, 1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 5'd0,  1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 5'd0,  1'b0, 1'b0, 3'd0, 16'h0000, 4'd0, 1'b0, 1'b0};

    kif.i_key_valid = 1'b0;
    kif.i_key_value = 5'd0;
    kif.i_cmd_ready = 1'b0;
    i_rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_model();
    i_rstn = 1'b1;

    // Scan tick: pulses in cycles 4, 8, 12 after release.
    mask = '0;
    for (int k = 0; k < 12; k++) begin
      mask[k] = kif.o_pls_1k;
      step(1'b0, 5'd0, 1'b0);
    end
    cmp("t1.pls_mask", 32'(mask), 32'h888);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].kv, tbl[i].code, tbl[i].rdy);
      cmp($sformatf("tbl%0d.vld", i),  32'(kif.o_cmd_valid),  32'(tbl[i].vld));
      cmp($sformatf("tbl%0d.op", i),   32'(kif.o_cmd_op),     32'(tbl[i].op));
      cmp($sformatf("tbl%0d.data", i), 32'(kif.o_cmd_data),   32'(tbl[i].data));
      cmp($sformatf("tbl%0d.cnt", i),  32'(kif.o_digit_cnt),  32'(tbl[i].cnt));
      cmp($sformatf("tbl%0d.busy", i), 32'(kif.o_entry_busy), 32'(tbl[i].busy));
      cmp($sformatf("tbl%0d.err", i),  32'(kif.o_err),        32'(tbl[i].err));
    end

    // Digits 4,5, BKSP, F2 with ready low for 10 cycles.
    step(1'b1, 5'd4, 1'b0);
    step(1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd12, 1'b0);
    step(1'b1, 5'd15, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cmp("t4.vld_held", 32'(kif.o_cmd_valid), 32'd1);
      cmp("t4.op",       32'(kif.o_cmd_op),    32'd2);
      cmp("t4.data",     32'(kif.o_cmd_data),  32'h0004);
      step(1'b0, 5'd0, 1'b0);
    end
    step(1'b0, 5'd0, 1'b1);
    cmp("t4.vld_dropped", 32'(kif.o_cmd_valid), 32'd0);
    cmp("t4.data_clear",  32'(kif.o_cmd_data),  32'h0);

    // Digit 7, then idle until the entry times out.
    step(1'b1, 5'd7, 1'b0);
    n = 0;
    saw_err = 1'b0;
    saw_vld = 1'b0;
    while (kif.o_entry_busy && n < 40) begin
      step(1'b0, 5'd0, 1'b0);
      n++;
      saw_err |= kif.o_err;
      saw_vld |= kif.o_cmd_valid;
    end
    cmp("t5.busy",      32'(kif.o_entry_busy), 32'd0);
    cmp("t5.cnt",       32'(kif.o_digit_cnt),  32'd0);
    cmp("t5.err_seen",  32'(saw_err),          32'd0);
    cmp("t5.vld_seen",  32'(saw_vld),          32'd0);
    cmp("t5.window",    32'(n >= 4 * (TIMEOUT_MS - 1) + 1 && n <= 4 * TIMEOUT_MS), 32'd1);

    // Asynchronous reset while a command is pending.
    step(1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd19, 1'b0);
    cmp("rst.pre_vld", 32'(kif.o_cmd_valid), 32'd1);
    i_rstn = 1'b0;
    kif.i_key_valid = 1'b0;
    #1;
    cmp("rst.vld",  32'(kif.o_cmd_valid),  32'd0);
    cmp("rst.op",   32'(kif.o_cmd_op),     32'd0);
    cmp("rst.data", 32'(kif.o_cmd_data),   32'd0);
    cmp("rst.cnt",  32'(kif.o_digit_cnt),  32'd0);
    cmp("rst.busy", 32'(kif.o_entry_busy), 32'd0);
    @(negedge i_clk);
    model_reset();
    i_rstn = 1'b1;

    for (int k = 0; k < 1500; k++) begin
      logic v, r;
      int c;
      v = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 31));
      r = ($urandom_range(0, 2) == 0);
      step(v, 5'(c), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
